// File: rtl/crc_rx_check.sv
// crc_rx_check: receive-side Ethernet FCS checker (reflected CRC-32).
//
// Absorbs a frame of DATA_W-bit beats (byte 0 in [7:0] is earliest on the wire),
// including the trailing 4-byte FCS, and reports whether the frame is intact
// by comparing the raw CRC register against the CRC-32 residue 0xDEBB20E3.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start_i      first beat of frame (qualified by valid_i)
//   valid_i      beat valid; no backpressure
//   last_i       final beat of frame (qualified by valid_i)
//   keep_i       LSB-contiguous byte enables, used on the last beat only
//   data_i       frame bytes
//   busy_o       frame in progress
//   crc_o        running CRC in FCS (complemented) form
//   res_valid_o  one-cycle result pulse, the cycle after the last beat
//   res_ok_o     FCS correct; held until the next result
//   err_cnt_o    saturating bad-frame count (only with CRC_RX_ERR_CNT_EN)
//
// Build option: define CRC_RX_ERR_CNT_EN to add the bad-frame counter and err_cnt_o.

module crc_rx_check #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic [31:0]       crc_o,
  output logic              res_valid_o,
  output logic              res_ok_o
`ifdef CRC_RX_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt_o
`endif
);

  localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic        res_valid_q, res_valid_d;
  logic        res_ok_q, res_ok_d;

  logic              beat_take;
  logic [KEEP_W-1:0] byte_en;
  logic [31:0]       crc_upd;

  // One byte through the reflected CRC, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] r;
    r = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CrcPoly) : (r >> 1);
    end
    return r;
  endfunction

  // A beat is consumed in ACC, or in IDLE only when it opens a frame.
  assign beat_take = valid_i && (start_i || (state_q == StAcc));
  assign byte_en   = last_i ? keep_i : {KEEP_W{1'b1}};

  // Whole beat folded in one cycle; start_i always restarts from init, which
  // also covers aborting a frame in progress.
  always_comb begin
    crc_upd = start_i ? CrcInit : crc_q;
    for (int k = 0; k < KEEP_W; k++) begin
      if (byte_en[k]) begin
        crc_upd = crc_byte(crc_upd, data_i[8*k +: 8]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    res_valid_d = 1'b0;
    res_ok_d    = res_ok_q;
    if (beat_take) begin
      crc_d = crc_upd;
      if (last_i) begin
        state_d     = StIdle;
        res_valid_d = 1'b1;
        res_ok_d    = (crc_upd == CrcResidue);
      end else begin
        state_d = StAcc;
      end
    end
  end

  // crc_q resets to all-ones so that the complemented output reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      crc_q       <= CrcInit;
      res_valid_q <= 1'b0;
      res_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      res_valid_q <= res_valid_d;
      res_ok_q    <= res_ok_d;
    end
  end

  assign busy_o      = (state_q == StAcc);
  assign crc_o       = ~crc_q;
  assign res_valid_o = res_valid_q;
  assign res_ok_o    = res_ok_q;

`ifdef CRC_RX_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts alongside the result pulse so err_cnt_o is current with res_valid_o.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (res_valid_d && !res_ok_d && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_rx_check.sv
// Self-checking bench for crc_rx_check: an 8-bit and a 32-bit instance driven
// with directed vectors and random frames, checked against a table-driven CRC-32.
module tb_crc_rx_check;

  typedef logic [7:0] byte_q_t[$];

  localparam int unsigned CntW    = 16;
  localparam logic [31:0] GoodFcs = 32'h2144_DF1C;  // ~residue: crc_o of an intact frame

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 8-bit instance
  logic        st8, vl8, ls8;
  logic [0:0]  kp8;
  logic [7:0]  d8;
  logic        busy8, rv8, ok8;
  logic [31:0] crc8;
  // 32-bit instance
  logic        st32, vl32, ls32;
  logic [3:0]  kp32;
  logic [31:0] d32;
  logic        busy32, rv32, ok32;
  logic [31:0] crc32;
`ifdef CRC_RX_ERR_CNT_EN
  logic [CntW-1:0] ec8, ec32;
`endif

  crc_rx_check #(.DATA_W(8), .CNT_W(CntW)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(st8), .valid_i(vl8), .last_i(ls8), .keep_i(kp8),
    .data_i(d8), .busy_o(busy8), .crc_o(crc8), .res_valid_o(rv8), .res_ok_o(ok8)
`ifdef CRC_RX_ERR_CNT_EN
    , .err_cnt_o(ec8)
`endif
  );

  crc_rx_check #(.DATA_W(32), .CNT_W(CntW)) u_dut32 (
    .clk(clk), .rst(rst), .start_i(st32), .valid_i(vl32), .last_i(ls32), .keep_i(kp32),
    .data_i(d32), .busy_o(busy32), .crc_o(crc32), .res_valid_o(rv32), .res_ok_o(ok32)
`ifdef CRC_RX_ERR_CNT_EN
    , .err_cnt_o(ec32)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;
  int pulses8  = 0;
  int pulses32 = 0;
  int exp_err8, exp_err32;
  logic [31:0] crc_tbl [256];

  always @(negedge clk) begin
    if (rv8 === 1'b1) pulses8++;
    if (rv32 === 1'b1) pulses32++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-at-a-time table model of reflected CRC-32; returns FCS form.
  function automatic logic [31:0] ref_crc(input byte_q_t q);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) c = crc_tbl[(c[7:0] ^ q[i])] ^ (c >> 8);
    return ~c;
  endfunction

  function automatic byte_q_t with_fcs(input byte_q_t q);
    logic [31:0] f = ref_crc(q);
    byte_q_t r = q;
    for (int i = 0; i < 4; i++) r.push_back(f[8*i +: 8]);
    return r;
  endfunction

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t r;
    for (int i = 0; i < n; i++) r.push_back(8'($urandom));
    return r;
  endfunction

  function automatic int bump(input int cnt, input logic good);
    if (!good && cnt < (1 << CntW) - 1) return cnt + 1;
    return cnt;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err8  = 0;
    exp_err32 = 0;
  endtask

  task automatic beat8(input logic st, input logic vl, input logic ls, input logic [7:0] d);
    st8 = st; vl8 = vl; ls8 = ls; kp8 = 1'b1; d8 = d;
    @(posedge clk); #1;
  endtask

  // Idle cycle with garbage on every qualified input.
  task automatic idle8();
    beat8(1'($urandom), 1'b0, 1'($urandom), 8'($urandom));
  endtask

  task automatic beat32(input logic st, input logic vl, input logic ls, input logic [3:0] kp,
                        input logic [31:0] d);
    st32 = st; vl32 = vl; ls32 = ls; kp32 = kp; d32 = d;
    @(posedge clk); #1;
  endtask

  task automatic idle32();
    beat32(1'($urandom), 1'b0, 1'($urandom), 4'($urandom), $urandom);
  endtask

  task automatic send8(input byte_q_t q, input int gap_pct, input string tag);
    logic [31:0] exp;
    logic        good;
    for (int i = 0; i < q.size(); i++) begin
      while ($urandom_range(99, 0) < gap_pct) idle8();
      beat8(i == 0, 1'b1, i == q.size() - 1, q[i]);
    end
    exp  = ref_crc(q);
    good = (exp == GoodFcs);
    exp_err8 = bump(exp_err8, good);
    check_eq({tag, ".rv"}, 32'(rv8), 32'd1);
    check_eq({tag, ".ok"}, 32'(ok8), 32'(good));
    check_eq({tag, ".crc"}, crc8, exp);
    check_eq({tag, ".busy"}, 32'(busy8), 32'd0);
`ifdef CRC_RX_ERR_CNT_EN
    check_eq({tag, ".errcnt"}, 32'(ec8), 32'(exp_err8));
`endif
    idle8();
    check_eq({tag, ".rv_off"}, 32'(rv8), 32'd0);
    check_eq({tag, ".ok_hold"}, 32'(ok8), 32'(good));
  endtask

  // empty_last: payload padded to whole words and closed by a keep=0 last beat.
  task automatic send32(input byte_q_t q_in, input logic empty_last, input int gap_pct,
                        input string tag);
    byte_q_t     q = q_in;
    logic [31:0] exp, w;
    logic [3:0]  kp;
    logic        good, ls;
    int          nbeats, r;
    if (empty_last) while (q.size() % 4 != 0) q.push_back(8'($urandom));
    nbeats = (q.size() + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) if (4*b + k < q.size()) w[8*k +: 8] = q[4*b + k];
      ls = !empty_last && (b == nbeats - 1);
      r  = q.size() - 4*b;
      kp = ls ? 4'((1 << r) - 1) : 4'($urandom);
      while ($urandom_range(99, 0) < gap_pct) idle32();
      beat32(b == 0, 1'b1, ls, kp, w);
    end
    if (empty_last) beat32(1'b0, 1'b1, 1'b1, 4'd0, $urandom);
    exp  = ref_crc(q);
    good = (exp == GoodFcs);
    exp_err32 = bump(exp_err32, good);
    check_eq({tag, ".rv"}, 32'(rv32), 32'd1);
    check_eq({tag, ".ok"}, 32'(ok32), 32'(good));
    check_eq({tag, ".crc"}, crc32, exp);
`ifdef CRC_RX_ERR_CNT_EN
    check_eq({tag, ".errcnt"}, 32'(ec32), 32'(exp_err32));
`endif
    idle32();
    check_eq({tag, ".rv_off"}, 32'(rv32), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy32), 32'd0);
  endtask

  initial begin
    byte_q_t     q, q2;
    int          p0;
    logic [31:0] c;

    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tbl[n] = c;
    end

    st8 = 0; vl8 = 0; ls8 = 0; kp8 = 0; d8 = 0;
    st32 = 0; vl32 = 0; ls32 = 0; kp32 = 0; d32 = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check_eq("rst.busy8", 32'(busy8), 32'd0);
    check_eq("rst.crc8", crc8, 32'd0);
    check_eq("rst.rv8", 32'(rv8), 32'd0);
    check_eq("rst.ok8", 32'(ok8), 32'd0);
    check_eq("rst.busy32", 32'(busy32), 32'd0);
    check_eq("rst.crc32", crc32, 32'd0);
`ifdef CRC_RX_ERR_CNT_EN
    check_eq("rst.ec8", 32'(ec8), 32'd0);
    check_eq("rst.ec32", 32'(ec32), 32'd0);
`endif

    // "123456789" check value on both widths
    q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    p0 = pulses8;
    send8(q, 0, "chk8");
    check_eq("chk8.const", crc8, 32'hCBF4_3926);
    check_eq("chk8.pulses", 32'(pulses8 - p0), 32'd1);
    send32(q, 1'b0, 0, "chk32");
    check_eq("chk32.const", crc32, 32'hCBF4_3926);

    // Same frame with its FCS, then with one corrupted bit
    do_reset();
    q2 = q;
    q2.push_back(8'h26); q2.push_back(8'h39); q2.push_back(8'hF4); q2.push_back(8'hCB);
    send8(q2, 0, "fcs_good");
    check_eq("fcs_good.ok_const", 32'(ok8), 32'd1);
    q2[0] = q2[0] ^ 8'h01;
    send8(q2, 0, "fcs_bad");
    check_eq("fcs_bad.ok_const", 32'(ok8), 32'd0);
`ifdef CRC_RX_ERR_CNT_EN
    check_eq("fcs_bad.ec_const", 32'(ec8), 32'd1);
`endif

    // Abort by restart after 3 beats, then a good frame: one result only
    p0 = pulses8;
    beat8(1'b1, 1'b1, 1'b0, 8'($urandom));
    beat8(1'b0, 1'b1, 1'b0, 8'($urandom));
    beat8(1'b0, 1'b1, 1'b0, 8'($urandom));
    check_eq("abort.busy", 32'(busy8), 32'd1);
    send8(with_fcs(rand_bytes(8)), 0, "abort");
    check_eq("abort.ok_const", 32'(ok8), 32'd1);
    check_eq("abort.pulses", 32'(pulses8 - p0), 32'd1);

    // Reset on beat 5 of a 13-beat frame, remaining beats still driven
    q  = with_fcs(rand_bytes(9));
    p0 = pulses8;
    for (int i = 0; i < 13; i++) begin
      if (i == 4) rst = 1'b1;
      beat8(i == 0, 1'b1, i == 12, q[i]);
      if (i == 4) begin
        rst = 1'b0;
        exp_err8  = 0;
        exp_err32 = 0;
        check_eq("rstmid.busy_now", 32'(busy8), 32'd0);
      end
    end
    idle8();
    check_eq("rstmid.pulses", 32'(pulses8 - p0), 32'd0);
    check_eq("rstmid.busy", 32'(busy8), 32'd0);
    check_eq("rstmid.crc", crc8, 32'd0);
    check_eq("rstmid.ok", 32'(ok8), 32'd0);

    // Random frames, half carrying a correct FCS, with idle gaps
    for (int n = 0; n < 40; n++) begin
      q = rand_bytes($urandom_range(24, 1));
      if (n % 2 == 0) q = with_fcs(q);
      send8(q, 20, "rnd8");
    end
    for (int n = 0; n < 40; n++) begin
      q = rand_bytes($urandom_range(30, 1));
      if (n % 2 == 0) q = with_fcs(q);
      send32(q, 1'($urandom), 20, "rnd32");
    end

`ifdef CRC_RX_ERR_CNT_EN
    // Back-to-back single-byte bad frames drive the counter into saturation
    q = {8'h00};
    for (int n = 0; n < 65536; n++) begin
      beat8(1'b1, 1'b1, 1'b1, 8'h00);
      exp_err8 = bump(exp_err8, ref_crc(q) == GoodFcs);
    end
    idle8();
    check_eq("sat.model", 32'(ec8), 32'(exp_err8));
    check_eq("sat.const", 32'(ec8), 32'h0000_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
